// File: rtl/sevseg_pkg.sv
// Shared constants for the multiplexed seven-segment display bus.
// Segment order is {g,f,e,d,c,b,a}, active low; anodes are active low.
// Used by both the display driver and the sevseg_capture monitor.
// The hex glyphs (SEG_A..SEG_F) only decode when SEVSEG_CAPTURE_HEX_EN is defined.
package sevseg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;
    typedef logic [3:0] code_t;

    // Decimal glyphs.
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;

    // Hex glyphs: A, b, C, d, E, F.
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;

    // All segments off.
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Anode bus with every digit switched off.
    localparam an_t AN_OFF = 4'b1111;

    // Code reported for a blank, missing or undecodable digit.
    localparam code_t CODE_INVALID = 4'hF;

    // Digit position of the single low anode bit (an[3] = leftmost digit).
    // Only meaningful when exactly one bit is low.
    function automatic logic [1:0] an_index(input an_t an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sevseg_capture_if.sv
// Seven-segment display bus as seen between a display driver (master)
// and a passive receiver such as sevseg_capture (slave).
interface sevseg_capture_if;
    import sevseg_pkg::*;

    seg_t seg_in;   // {g,f,e,d,c,b,a}, active low
    an_t  an_in;    // active low, an_in[3] = leftmost digit

    modport master (output seg_in, output an_in);
    modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/seg_decode.sv
// Combinational seven-segment pattern to BCD decoder.
// Blank (all segments off) reports CODE_INVALID with is_blank set; any pattern that is
// not a known glyph reports CODE_INVALID with is_bad set.
// SEVSEG_CAPTURE_HEX_EN adds the A..F glyphs as codes 4'hA..4'hF.
module seg_decode
    import sevseg_pkg::*;
(
    input  seg_t  seg,
    output code_t code,
    output logic  is_blank,
    output logic  is_bad
);

    // Map one segment pattern to its digit code and status flags.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave one unassigned (no latch).
        code     = CODE_INVALID;
        is_blank = 1'b0;
        is_bad   = 1'b0;
        case (seg)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_BLANK: is_blank = 1'b1;
`ifdef SEVSEG_CAPTURE_HEX_EN
            SEG_A:     code = 4'hA;
            SEG_B:     code = 4'hB;
            SEG_C:     code = 4'hC;
            SEG_D:     code = 4'hD;
            SEG_E:     code = 4'hE;
            SEG_F:     code = 4'hF;
`endif
            default:   is_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevseg_capture.sv
// Passive receiver for the multiplexed seven-segment display bus.
// Registers the bus once, waits for each anode dwell to settle, samples it once, decodes
// the glyph and assembles the four digits into a frame {d3,d2,d1,d0}. A long gap with
// no accepted sample commits whatever was seen and raises stale.
// Optional feature: define SEVSEG_CAPTURE_HEX_EN to also decode the A..F glyphs.
module sevseg_capture
    import sevseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
)(
    input  logic              clk,
    input  logic              reset,
    sevseg_capture_if.slave   bus,
    output logic [15:0]       digits,
    output logic [3:0]        blank,
    output logic              frame_valid,
    output logic              bad_pattern,
    output logic              stale
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    // Settle counter saturates on the sample point itself.
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    // Timeout counter saturates on its last value; the event fires on the step into it,
    // which limits a gap to a single partial commit.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_PRE  = TW'(TIMEOUT_CYCLES - 2);

    // Registered bus and its one-cycle-older copy for change detection.
    seg_t seg_q, seg_p;
    an_t  an_q,  an_p;

    logic [SW-1:0] settle_cnt;
    logic          armed;
    logic [TW-1:0] timeout_cnt;

    // Frame assembly state.
    logic [3:0]       seen;
    logic [3:0][3:0]  shadow_code;
    logic [3:0]       shadow_blank;

    // Combinational helpers.
    logic            changed;
    logic            an_onehot;
    logic            sample;
    logic [1:0]      sample_idx;
    code_t           dec_code;
    logic            dec_blank;
    logic            dec_bad;
    logic [3:0]      next_seen;
    logic [3:0][3:0] next_code;
    logic [3:0]      next_blank;
    logic [3:0][3:0] commit_code;
    logic [3:0]      commit_blank;
    logic            timeout_hit;
    logic            commit;

    // Register the bus once and keep the previous registered value.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so seg_p takes the pre-edge seg_q and not the new one.
        if (reset) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
            seg_p <= SEG_BLANK;
            an_p  <= AN_OFF;
        end else begin
            seg_q <= bus.seg_in;
            an_q  <= bus.an_in;
            seg_p <= seg_q;
            an_p  <= an_q;
        end
    end

    // Settled, single-digit and not yet sampled in this dwell. The change term stops a
    // saturated counter from sampling the first cycle of a new dwell.
    assign changed   = (seg_q != seg_p) || (an_q != an_p);
    assign an_onehot = $onehot(~an_q);
    assign sample    = !changed && (settle_cnt == SETTLE_LAST) && an_onehot && !armed;

    // Settle counter and one-sample-per-dwell arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (changed) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_LAST) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
            if (sample) begin
                armed <= 1'b1;
            end
        end
    end

    seg_decode u_seg_decode (
        .seg      (seg_q),
        .code     (dec_code),
        .is_blank (dec_blank),
        .is_bad   (dec_bad)
    );

    // Merge the current sample (if any) into the shadow frame and seen mask.
    always_comb begin
        sample_idx = an_index(an_q);
        next_code  = shadow_code;
        next_blank = shadow_blank;
        next_seen  = seen;
        if (sample) begin
            next_code[sample_idx]  = dec_code;
            next_blank[sample_idx] = dec_blank;
            next_seen[sample_idx]  = 1'b1;
        end
    end

    // Build the committed frame: digits not seen show as invalid and blank.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            commit_code[k]  = next_seen[k] ? next_code[k]  : CODE_INVALID;
            commit_blank[k] = next_seen[k] ? next_blank[k] : 1'b1;
        end
    end

    // A sample in the same cycle as the timeout wins and suppresses it.
    assign timeout_hit = !sample && (timeout_cnt == TIMEOUT_PRE);
    assign commit      = (next_seen == 4'b1111) || (timeout_hit && (seen != 4'b0000));

    // Shadow frame, seen mask and committed outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shadow is four nibbles, so it is reset like the rest; reset also drops a partial frame.
            shadow_code  <= '{default: CODE_INVALID};
            shadow_blank <= 4'b1111;
            seen         <= 4'b0000;
            digits       <= 16'hFFFF;
            blank        <= 4'b1111;
            frame_valid  <= 1'b0;
        end else begin
            shadow_code  <= next_code;
            shadow_blank <= next_blank;
            frame_valid  <= commit;
            if (commit) begin
                seen   <= 4'b0000;
                digits <= commit_code;
                blank  <= commit_blank;
            end else begin
                seen   <= next_seen;
            end
        end
    end

    // One-cycle pulse for an undecodable sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_pattern <= 1'b0;
        end else begin
            bad_pattern <= sample && dec_bad;
        end
    end

    // Gap timer since the last accepted sample and the stale level it drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt <= '0;
            stale       <= 1'b0;
        end else if (sample) begin
            timeout_cnt <= '0;
            stale       <= 1'b0;
        end else begin
            if (timeout_cnt != TIMEOUT_LAST) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end
            if (timeout_hit) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture with hand-computed expectations.
// Expectations for the A glyph follow SEVSEG_CAPTURE_HEX_EN.
module tb_sevseg_capture;
    import sevseg_pkg::*;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;
    localparam seg_t SEG_JUNK = 7'b0110110;   // not a glyph in either build

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        bad_pattern;
    logic        stale;

    sevseg_capture_if bus ();

    sevseg_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .digits      (digits),
        .blank       (blank),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fv_count = 0;
    int          bad_count = 0;
    logic [15:0] last_digits = 16'h0000;
    logic [3:0]  last_blank  = 4'h0;
    longint      fv_time = 0;
    longint      scan_t3 = 0;
    int          f0;
    int          b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every committed frame and every bad-pattern pulse.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count++;
            last_digits = digits;
            last_blank  = blank;
            fv_time     = $time;
        end
        if (bad_pattern === 1'b1) begin
            bad_count++;
        end
    end

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        dwell(4'b1110, s0, 32);
        dwell(4'b1101, s1, 32);
        dwell(4'b1011, s2, 32);
        scan_t3 = $time;
        dwell(4'b0111, s3, 32);
        dwell(4'b1111, SEG_BLANK, 4);
    endtask

    // Hard stop in case something never returns.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.an_in  = 4'b1111;
        bus.seg_in = SEG_BLANK;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0000FFFF);
        check("rst_blank",  32'(blank), 32'hF);
        check("rst_fv",     32'(frame_valid), 32'h0);
        check("rst_bad",    32'(bad_pattern), 32'h0);
        check("rst_stale",  32'(stale), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: plain frame 1,0,3,7. Bus changes at a negedge, is registered 5 units later,
        // settles for 16 more edges, and frame_valid is seen 18 clock periods after the change.
        f0 = fv_count; b0 = bad_count;
        scan(SEG_7, SEG_3, SEG_0, SEG_1);
        check("t1_fv_count", 32'(fv_count - f0), 32'd1);
        check("t1_digits",   32'(last_digits), 32'h1037);
        check("t1_blank",    32'(last_blank), 32'h0);
        check("t1_latency",  32'(fv_time - scan_t3), 32'd180);
        check("t1_no_bad",   32'(bad_count - b0), 32'd0);

        // 2: a fast-toggling dwell (junk glyph included) must not be sampled.
        f0 = fv_count; b0 = bad_count;
        for (int i = 0; i < 6; i++) begin
            dwell(4'b1110, (i % 2 == 1) ? SEG_8 : SEG_JUNK, 8);
        end
        dwell(4'b1110, SEG_5, 20);
        dwell(4'b1101, SEG_2, 32);
        dwell(4'b1011, SEG_4, 32);
        dwell(4'b0111, SEG_9, 32);
        dwell(4'b1111, SEG_BLANK, 4);
        check("t2_no_bad",   32'(bad_count - b0), 32'd0);
        check("t2_fv_count", 32'(fv_count - f0), 32'd1);
        check("t2_digits",   32'(last_digits), 32'h9425);

        // 3: blank d2.
        f0 = fv_count; b0 = bad_count;
        scan(SEG_7, SEG_3, SEG_BLANK, SEG_1);
        check("t3_fv_count", 32'(fv_count - f0), 32'd1);
        check("t3_digits",   32'(last_digits), 32'h1F37);
        check("t3_blank",    32'(last_blank), 32'b0100);
        check("t3_no_bad",   32'(bad_count - b0), 32'd0);

        // 4: A glyph in d1.
        f0 = fv_count; b0 = bad_count;
        scan(SEG_2, SEG_A, SEG_6, SEG_4);
        check("t4_fv_count", 32'(fv_count - f0), 32'd1);
        check("t4_blank",    32'(last_blank), 32'h0);
`ifdef SEVSEG_CAPTURE_HEX_EN
        check("t4_digits",   32'(last_digits), 32'h46A2);
        check("t4_bad",      32'(bad_count - b0), 32'd0);
`else
        check("t4_digits",   32'(last_digits), 32'h46F2);
        check("t4_bad",      32'(bad_count - b0), 32'd1);
`endif

        // 4b: junk glyph in d3 is bad in both builds; also covers 8, 9 and 5.
        f0 = fv_count; b0 = bad_count;
        scan(SEG_8, SEG_9, SEG_5, SEG_JUNK);
        check("t4b_fv_count", 32'(fv_count - f0), 32'd1);
        check("t4b_digits",   32'(last_digits), 32'hF598);
        check("t4b_blank",    32'(last_blank), 32'h0);
        check("t4b_bad",      32'(bad_count - b0), 32'd1);

        // 5: two digits then silence -> one partial commit after the timeout.
        f0 = fv_count;
        dwell(4'b1110, SEG_4, 32);
        dwell(4'b1101, SEG_6, 32);
        dwell(4'b1111, SEG_BLANK, 1);
        check("t5_stale_before", 32'(stale), 32'h0);
        repeat (899) @(negedge clk);
        check("t5_not_yet_stale", 32'(stale), 32'h0);
        check("t5_not_yet_fv",    32'(fv_count - f0), 32'd0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fv_count != f0) break;
        end
        repeat (2) @(negedge clk);
        check("t5_fv_count", 32'(fv_count - f0), 32'd1);
        check("t5_digits",   32'(last_digits), 32'hFF64);
        check("t5_blank",    32'(last_blank), 32'b1100);
        check("t5_stale",    32'(stale), 32'h1);
        repeat (1200) @(negedge clk);
        check("t5_single_commit", 32'(fv_count - f0), 32'd1);
        check("t5_stale_held",    32'(stale), 32'h1);
        dwell(4'b1110, SEG_3, 32);
        check("t5_stale_cleared", 32'(stale), 32'h0);

        // 6: reset after two digits, then an=1100 dwell and a fresh scan.
        dwell(4'b1110, SEG_1, 32);
        dwell(4'b1101, SEG_2, 32);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_digits", 32'(digits), 32'h0000FFFF);
        check("t6_rst_blank",  32'(blank), 32'hF);
        check("t6_rst_fv",     32'(frame_valid), 32'h0);
        check("t6_rst_stale",  32'(stale), 32'h0);
        reset = 1'b0;
        f0 = fv_count; b0 = bad_count;
        dwell(4'b1100, SEG_JUNK, 32);
        dwell(4'b1011, SEG_9, 32);
        dwell(4'b0111, SEG_3, 32);
        check("t6_no_early_fv", 32'(fv_count - f0), 32'd0);
        dwell(4'b1110, SEG_5, 32);
        dwell(4'b1101, SEG_4, 32);
        dwell(4'b1111, SEG_BLANK, 4);
        check("t6_fv_count", 32'(fv_count - f0), 32'd1);
        check("t6_digits",   32'(last_digits), 32'h3945);
        check("t6_blank",    32'(last_blank), 32'h0);
        check("t6_no_bad",   32'(bad_count - b0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
